// File: rtl/ip_tx.sv
// IPv4 transmit stage: wraps an upstream payload in a 20-byte IPv4 header
// (with computed checksum) and streams it to the MAC send interface.
module ip_tx #(
    parameter logic [31:0] P_SOURCE_IP   = {8'd192, 8'd168, 8'd1, 8'd100},
    parameter logic [31:0] P_TARGET_IP   = {8'd192, 8'd168, 8'd1, 8'd1},
    parameter logic [7:0]  P_TTL         = 8'd64,
    parameter logic [15:0] P_MAX_PAYLOAD = 16'd1480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_source_ip,
    input  logic        i_source_ip_valid,
    input  logic [31:0] i_target_ip,
    input  logic        i_target_ip_valid,
    input  logic        i_up_valid,
    input  logic [15:0] i_up_len,
    input  logic [7:0]  i_up_protocol,
    output logic        o_up_ready,
    input  logic [7:0]  i_up_data,
    input  logic        i_up_last,
    output logic        o_mac_req,
    input  logic        i_mac_ready,
    output logic [15:0] o_send_type,
    output logic [15:0] o_send_len,
    output logic [7:0]  o_send_data,
    output logic        o_send_last,
    output logic        o_send_valid,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC1, S_CALC2, S_REQ, S_HDR, S_PAY, S_DROP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_short, w_short_nxt;
    logic [31:0] r_src_ip, r_tgt_ip, r_hdr_src, r_hdr_tgt;
    logic [15:0] r_len, r_tot, r_ident, r_csum;
    logic [7:0]  r_proto;
    logic [31:0] r_sum;

    logic        w_len_ok, w_pay_end;
    logic [31:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic [159:0] w_hdr, w_hdr_sh;
    logic        w_mac_req, w_valid, w_last, w_up_ready, w_err;
    logic [7:0]  w_data;

    assign w_len_ok  = (i_up_len != 16'd0) && (i_up_len <= P_MAX_PAYLOAD);
    assign w_pay_end = (r_cnt == r_len - 16'd1);

    // 0x4500 + 0x4000 folded into one constant; checksum word counts as zero
    assign w_sum = 32'h0000_8500 + 32'(r_tot) + 32'(r_ident) + 32'({P_TTL, r_proto})
                 + 32'(r_hdr_src[31:16]) + 32'(r_hdr_src[15:0])
                 + 32'(r_hdr_tgt[31:16]) + 32'(r_hdr_tgt[15:0]);
    assign w_fold1 = 17'(r_sum[15:0]) + 17'(r_sum[31:16]);
    assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);

    assign w_hdr    = {16'h4500, r_tot, r_ident, 16'h4000, P_TTL, r_proto, r_csum,
                       r_hdr_src, r_hdr_tgt};
    assign w_hdr_sh = w_hdr >> {5'd19 - r_cnt[4:0], 3'b000};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_short_nxt = r_short;
        w_mac_req   = 1'b0;
        w_valid     = 1'b0;
        w_data      = '0;
        w_last      = 1'b0;
        w_up_ready  = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_short_nxt = 1'b0;
                if (i_up_valid) w_state_nxt = w_len_ok ? S_CALC1 : S_DROP;
            end
            S_CALC1: w_state_nxt = S_CALC2;
            S_CALC2: begin
                w_state_nxt = S_REQ;
                w_mac_req   = 1'b1;
            end
            S_REQ: begin
                if (i_mac_ready) begin
                    w_state_nxt = S_HDR;
                    w_valid     = 1'b1;
                    w_data      = w_hdr_sh[7:0];
                    w_cnt_nxt   = 16'd1;
                end else begin
                    w_mac_req = 1'b1;
                end
            end
            S_HDR: begin
                w_valid    = 1'b1;
                w_data     = w_hdr_sh[7:0];
                w_up_ready = (r_cnt == 16'd18);
                if (r_cnt == 16'd19) begin
                    w_state_nxt = S_PAY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_PAY: begin
                w_valid = 1'b1;
                // once an early last has been seen, upstream is finished; pad with zeros
                if (!r_short && i_up_valid) w_data = i_up_data;
                if (!r_short) begin
                    if (!i_up_valid) begin
                        w_err = 1'b1;
                    end else if (i_up_last && !w_pay_end) begin
                        w_err       = 1'b1;
                        w_short_nxt = 1'b1;
                    end else if (!i_up_last && w_pay_end) begin
                        w_err = 1'b1;
                    end
                end
                if (w_pay_end) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_DROP: begin
                if (r_cnt == 16'd0) begin
                    w_up_ready = 1'b1;
                    w_err      = 1'b1;
                    w_cnt_nxt  = 16'd1;
                end else if (i_up_valid && i_up_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_short      <= 1'b0;
            o_mac_req    <= 1'b0;
            o_up_ready   <= 1'b0;
            o_err        <= 1'b0;
            o_send_valid <= 1'b0;
            o_send_data  <= '0;
            o_send_last  <= 1'b0;
            o_send_type  <= '0;
            o_send_len   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_short      <= w_short_nxt;
            o_mac_req    <= w_mac_req;
            o_up_ready   <= w_up_ready;
            o_err        <= w_err;
            o_send_valid <= w_valid;
            o_send_data  <= w_data;
            o_send_last  <= w_last;
            o_send_type  <= w_valid ? 16'h0800 : 16'h0000;
            o_send_len   <= w_valid ? r_tot : 16'h0000;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_src_ip  <= P_SOURCE_IP;
            r_tgt_ip  <= P_TARGET_IP;
            r_hdr_src <= P_SOURCE_IP;
            r_hdr_tgt <= P_TARGET_IP;
            r_len     <= '0;
            r_tot     <= '0;
            r_proto   <= '0;
            r_ident   <= '0;
            r_sum     <= '0;
            r_csum    <= '0;
        end else begin
            if (i_source_ip_valid) r_src_ip <= i_source_ip;
            if (i_target_ip_valid) r_tgt_ip <= i_target_ip;
            if (r_state == S_IDLE && i_up_valid) begin
                r_len     <= i_up_len;
                r_tot     <= i_up_len + 16'd20;
                r_proto   <= i_up_protocol;
                r_hdr_src <= r_src_ip;
                r_hdr_tgt <= r_tgt_ip;
            end
            if (r_state == S_CALC1) r_sum <= w_sum;
            if (r_state == S_CALC2) r_csum <= ~w_fold2;
            if (r_state == S_PAY && w_pay_end) r_ident <= r_ident + 16'd1;
        end
    end

endmodule

// File: tb/tb_ip_tx.sv
// Randomized bench for ip_tx: a byte-level frame model (header built with
// end-around-carry checksum) feeds a queue checked against the DUT every cycle.
module tb_ip_tx;

    localparam logic [31:0] DEF_SRC = {8'd192, 8'd168, 8'd1, 8'd100};
    localparam logic [31:0] DEF_TGT = {8'd192, 8'd168, 8'd1, 8'd1};

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [31:0] i_source_ip = '0;
    logic        i_source_ip_valid = 1'b0;
    logic [31:0] i_target_ip = '0;
    logic        i_target_ip_valid = 1'b0;
    logic        i_up_valid = 1'b0;
    logic [15:0] i_up_len = '0;
    logic [7:0]  i_up_protocol = '0;
    logic        o_up_ready;
    logic [7:0]  i_up_data = '0;
    logic        i_up_last = 1'b0;
    logic        o_mac_req;
    logic        i_mac_ready = 1'b0;
    logic [15:0] o_send_type, o_send_len;
    logic [7:0]  o_send_data;
    logic        o_send_last, o_send_valid, o_err;

    ip_tx #(
        .P_SOURCE_IP  (DEF_SRC),
        .P_TARGET_IP  (DEF_TGT),
        .P_TTL        (8'd64),
        .P_MAX_PAYLOAD(16'd1480)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_source_ip(i_source_ip), .i_source_ip_valid(i_source_ip_valid),
        .i_target_ip(i_target_ip), .i_target_ip_valid(i_target_ip_valid),
        .i_up_valid(i_up_valid), .i_up_len(i_up_len), .i_up_protocol(i_up_protocol),
        .o_up_ready(o_up_ready), .i_up_data(i_up_data), .i_up_last(i_up_last),
        .o_mac_req(o_mac_req), .i_mac_ready(i_mac_ready),
        .o_send_type(o_send_type), .o_send_len(o_send_len), .o_send_data(o_send_data),
        .o_send_last(o_send_last), .o_send_valid(o_send_valid), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0]  d;
        logic        l;
        logic [15:0] len;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;
    int          err_seen = 0, err_exp = 0, upr_seen = 0, upr_exp = 0, mreq_cyc = 0;
    logic        chk_en = 1'b0;
    logic        in_frame = 1'b0;
    logic [7:0]  cap[64];
    int          cap_n = 0;
    logic [31:0] m_src = DEF_SRC, m_tgt = DEF_TGT;
    logic [15:0] m_ident = '0;
    int          mac_delay = 1;
    logic [7:0]  lit[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] csum_of(input logic [15:0] tot, input logic [15:0] ident,
                                            input logic [7:0] proto, input logic [31:0] src,
                                            input logic [31:0] tgt);
        logic [15:0] w[10];
        logic [16:0] acc;
        w = '{16'h4500, tot, ident, 16'h4000, {8'd64, proto}, 16'h0000,
              src[31:16], src[15:0], tgt[31:16], tgt[15:0]};
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            acc = 17'(acc[15:0]) + 17'(w[i]);
            acc = 17'(acc[15:0]) + 17'(acc[16]);
        end
        return ~acc[15:0];
    endfunction

    // every-cycle compare against the expected byte queue
    always @(negedge i_clk) begin
        if (chk_en) begin
            if (o_err) err_seen++;
            if (o_up_ready) upr_seen++;
            if (o_mac_req) mreq_cyc++;
            if (o_send_valid) begin
                if (!in_frame) cap_n = 0;
                if (q.size() == 0) begin
                    check("queue_occupancy", 32'(q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("send_data", {24'd0, o_send_data}, {24'd0, e.d});
                    check("send_last", {31'd0, o_send_last}, {31'd0, e.l});
                    check("send_len", {16'd0, o_send_len}, {16'd0, e.len});
                    check("send_type", {16'd0, o_send_type}, 32'h0800);
                end
                if (cap_n < 64) cap[cap_n] = o_send_data;
                cap_n++;
                in_frame = !o_send_last;
            end else begin
                if (in_frame) begin
                    check("frame_gap", {31'd0, o_send_valid}, 32'd1);
                    in_frame = 1'b0;
                end
                check("idle_type_len", {o_send_type, o_send_len}, 32'd0);
                check("idle_last", {31'd0, o_send_last}, 32'd0);
            end
        end
    end

    // MAC grant model: grant after the request has been visible mac_delay cycles
    initial begin
        int mcnt;
        mcnt = 0;
        forever begin
            @(posedge i_clk); #1;
            if (o_mac_req) mcnt++; else mcnt = 0;
            i_mac_ready = o_mac_req && (mcnt >= mac_delay);
        end
    end

    // mode: 0 clean, 1 valid dropped at pos, 2 early last at pos, 3 last missing
    task automatic send(input int n, input logic [7:0] proto, input int mode, input int pos,
                        input int delay, input bit tgt_upd, input logic [31:0] new_tgt);
        logic [7:0]   d[64];
        bit           v[64], l[64];
        bit           ok, got, short_f;
        int           e, p;
        logic [15:0]  cks, tot;
        logic [159:0] hdr;
        ok = (n >= 1 && n <= 1480);
        mac_delay = delay;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                d[i] = 8'($urandom);
                v[i] = 1'b1;
                l[i] = (i == n - 1);
            end
            p = (pos >= 0) ? pos : ((n >= 2) ? $urandom_range(0, n - 2) : 0);
            if (mode == 1 && n >= 2) v[p] = 1'b0;
            if (mode == 2 && n >= 2) begin
                l[n-1] = 1'b0;
                l[p]   = 1'b1;
                for (int i = p + 1; i < n; i++) begin v[i] = 1'b0; d[i] = 8'h00; end
            end
            if (mode == 3) l[n-1] = 1'b0;
            tot = 16'(n + 20);
            cks = csum_of(tot, m_ident, proto, m_src, m_tgt);
            hdr = {16'h4500, tot, m_ident, 16'h4000, 8'd64, proto, cks, m_src, m_tgt};
            for (int i = 0; i < 20; i++) q.push_back('{hdr[159 - 8*i -: 8], 1'b0, tot});
            e = 0;
            short_f = 1'b0;
            for (int i = 0; i < n; i++) begin
                logic [7:0] ob;
                ob = 8'h00;
                if (!short_f) begin
                    if (!v[i]) e++;
                    else begin
                        ob = d[i];
                        if (l[i] && i < n - 1) begin e++; short_f = 1'b1; end
                        else if (!l[i] && i == n - 1) e++;
                    end
                end
                q.push_back('{ob, (i == n - 1), tot});
            end
            err_exp += e;
            m_ident++;
        end else begin
            err_exp++;
        end
        upr_exp++;
        i_up_len = 16'(n); i_up_protocol = proto; i_up_valid = 1'b1;
        i_up_last = 1'b0; i_up_data = 8'h00;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge i_clk); #1;
            if (o_up_ready) got = 1'b1;
        end
        check("up_ready_seen", {31'd0, got}, 32'd1);
        @(posedge i_clk); #1;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                i_up_valid = v[i]; i_up_data = d[i]; i_up_last = l[i];
                if (tgt_upd && i == 1) begin
                    i_target_ip = new_tgt; i_target_ip_valid = 1'b1; m_tgt = new_tgt;
                end
                @(posedge i_clk); #1;
                i_target_ip_valid = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                i_up_valid = 1'b1; i_up_data = 8'($urandom); i_up_last = (i == 3);
                @(posedge i_clk); #1;
            end
        end
        i_up_valid = 1'b0; i_up_last = 1'b0; i_up_data = 8'h00;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (q.size() != 0 || o_send_valid); k++) @(posedge i_clk);
        repeat (3) @(posedge i_clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        check("err_pulses", 32'(err_seen), 32'(err_exp));
        check("up_ready_pulses", 32'(upr_seen), 32'(upr_exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int mc, n, mode;
        bit got;
        lit = '{8'h45, 8'h00, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'hB7, 8'h19, 8'hC0, 8'hA8, 8'h01, 8'h64, 8'hC0, 8'hA8, 8'h01, 8'h01};
        #1;
        check("rst_send", {o_send_valid, o_send_last, o_send_data, o_send_len}, 32'd0);
        check("rst_ctrl", {o_mac_req, o_up_ready, o_err, o_send_type}, 32'd0);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b1;
        chk_en = 1'b1;

        // idle: no request for 50 cycles
        repeat (50) @(posedge i_clk);
        #1;
        check("idle_mac_req_cycles", 32'(mreq_cyc), 32'd0);

        // reference datagram with hand-computed header
        check("model_csum_pin", {16'd0, csum_of(16'd30, 16'd0, 8'd17, DEF_SRC, DEF_TGT)}, 32'hB719);
        send(10, 8'd17, 0, -1, 3, 1'b0, '0);
        drain();
        check("frame_bytes", 32'(cap_n), 32'd30);
        for (int i = 0; i < 20; i++) check("hdr_byte", {24'd0, cap[i]}, {24'd0, lit[i]});

        // back-to-back, identification advances
        send(2, 8'd17, 0, -1, 1, 1'b0, '0);
        send(2, 8'd17, 0, -1, 1, 1'b0, '0);
        drain();
        check("b2b_ident_lo", {24'd0, cap[5]}, 32'h02);

        // illegal lengths are dropped without a MAC request
        mc = mreq_cyc;
        send(0, 8'd17, 0, -1, 1, 1'b0, '0);
        send(1481, 8'd17, 0, -1, 1, 1'b0, '0);
        drain();
        check("drop_no_mac_req", 32'(mreq_cyc), 32'(mc));

        // early last on byte 1 of 4
        send(4, 8'd17, 2, 1, 2, 1'b0, '0);
        drain();
        check("short_pad2", {24'd0, cap[22]}, 32'h00);
        check("short_pad3", {24'd0, cap[23]}, 32'h00);

        // target IP changed mid-payload applies to the next frame only
        send(6, 8'd6, 0, -1, 2, 1'b1, 32'h0A00_0001);
        send(3, 8'd6, 0, -1, 2, 1'b0, '0);
        drain();
        check("new_target", {cap[16], cap[17], cap[18], cap[19]}, 32'h0A00_0001);

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                i_source_ip = $urandom; i_source_ip_valid = 1'b1; m_src = i_source_ip;
                @(posedge i_clk); #1;
                i_source_ip_valid = 1'b0;
            end
            case ($urandom_range(0, 7))
                0:       n = 0;
                1:       n = 1481 + $urandom_range(0, 200);
                default: n = $urandom_range(1, 40);
            endcase
            mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            send(n, 8'($urandom), mode, -1, $urandom_range(1, 5), 1'b0, '0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        // asynchronous reset in the middle of the header
        chk_en = 1'b0;
        mac_delay = 1;
        i_up_len = 16'd8; i_up_protocol = 8'd17; i_up_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge i_clk); #1;
            if (o_send_valid) got = 1'b1;
        end
        check("hdr_started", {31'd0, got}, 32'd1);
        i_rst = 1'b0;
        #1;
        check("async_rst_send", {o_send_valid, o_send_last, o_send_data, o_send_len}, 32'd0);
        check("async_rst_ctrl", {o_mac_req, o_up_ready, o_err, o_send_type}, 32'd0);
        i_up_valid = 1'b0;
        q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        m_ident = '0; m_src = DEF_SRC; m_tgt = DEF_TGT;
        err_exp = err_seen; upr_exp = upr_seen;
        in_frame = 1'b0;
        chk_en = 1'b1;
        send(10, 8'd17, 0, -1, 3, 1'b0, '0);
        drain();
        for (int i = 0; i < 20; i++) check("post_rst_hdr", {24'd0, cap[i]}, {24'd0, lit[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
